// File: rtl/cypher_scan_pkg.sv
// Shared types and helpers for the cypher scan accumulator.
//   state_t  : controller states
//   sym_at   : extract symbol k of a packed word (symbol 0 in the MSB field)
//   sat_add  : saturating add clamped to a run-time width
//   sat_hit  : flags that the same add would exceed that width
package cypher_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Helpers work on fixed maximum widths; callers extend/truncate with casts.
    localparam int MAX_WORD_W = 512;
    localparam int MAX_SYM_W  = 16;
    localparam int MAX_SUM_W  = 31;
    localparam int ACC_W      = MAX_SUM_W + 1;

    function automatic logic [MAX_SYM_W-1:0] sym_at(
        input logic [MAX_WORD_W-1:0] word,
        input int                    n_sym,
        input int                    sym_w,
        input int                    k
    );
        return MAX_SYM_W'(word >> ((n_sym - 1 - k) * sym_w))
             & MAX_SYM_W'((32'd1 << sym_w) - 32'd1);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input int               sum_w
    );
        logic [ACC_W-1:0] lim;
        lim = (ACC_W'(1) << sum_w) - ACC_W'(1);
        return ((a + b) > lim) ? lim : (a + b);
    endfunction

    function automatic logic sat_hit(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input int               sum_w
    );
        logic [ACC_W-1:0] lim;
        lim = (ACC_W'(1) << sum_w) - ACC_W'(1);
        return (a + b) > lim;
    endfunction

endpackage

// File: rtl/cypher_sat_acc.sv
// Saturating accumulator with sticky overflow.
//   CLK, reset  : clock, synchronous active-high reset
//   i_clr       : clear sum and overflow (new run)
//   i_commit    : add i_addend into the sum
//   i_addend    : SUM_W+1 bit value of a completed match
//   o_sum       : clamped running sum
//   o_overflow  : set once any commit saturated; held until clear/reset
module cypher_sat_acc
    import cypher_scan_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_commit,
    input  logic [SUM_W:0]   i_addend,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_overflow
);

    logic [SUM_W-1:0] r_sum;
    logic             r_ovf;
    logic [SUM_W-1:0] w_sum_next;
    logic             w_sat;

    assign w_sum_next = SUM_W'(sat_add(ACC_W'(r_sum), ACC_W'(i_addend), SUM_W));
    assign w_sat      = sat_hit(ACC_W'(r_sum), ACC_W'(i_addend), SUM_W);

    always_ff @(posedge CLK) begin
        if (reset || i_clr) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (i_commit) begin
            r_sum <= w_sum_next;
            if (w_sat)
                r_ovf <= 1'b1;
        end
    end

    assign o_sum      = r_sum;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/cypher_scan_accum.sv
// Cypher pattern scanner: walks a captured data word one symbol per cycle,
// counts non-overlapping occurrences of the captured pattern and accumulates
// the symbol values of completed matches (saturating).
//   CLK, reset : clock, synchronous active-high reset
//   start      : run request, accepted in IDLE/DONE only
//   in, cypher : data word and pattern, symbol 0 in the MSB field
//   busy       : high in LOAD and SCAN
//   done       : one-cycle pulse on entry to DONE
//   sum, match_cnt, overflow : run result, held until next start
module cypher_scan_accum
    import cypher_scan_pkg::*;
#(
    parameter int SYM_W   = 4,
    parameter int N_SYM   = 16,
    parameter int PAT_LEN = 4,
    parameter int SUM_W   = 8
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N_SYM*SYM_W-1:0]               in,
    input  logic [PAT_LEN*SYM_W-1:0]             cypher,
    output logic                                 busy,
    output logic                                 done,
    output logic [SUM_W-1:0]                     sum,
    output logic [$clog2(N_SYM/PAT_LEN+1)-1:0]   match_cnt,
    output logic                                 overflow
);

    localparam int IDX_W = $clog2(N_SYM);
    localparam int POS_W = $clog2(PAT_LEN);
    localparam int CNT_W = $clog2(N_SYM/PAT_LEN+1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYM - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(PAT_LEN - 1);

    state_t                     r_state;
    logic [N_SYM*SYM_W-1:0]     r_word;
    logic [PAT_LEN*SYM_W-1:0]   r_pat;
    logic [IDX_W-1:0]           r_idx;
    logic [POS_W-1:0]           r_pos;
    logic [SUM_W:0]             r_partial;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_busy;
    logic                       r_done;

    logic [SYM_W-1:0]           w_sym;
    logic [SYM_W-1:0]           w_pat_cur;
    logic [SYM_W-1:0]           w_pat0;
    logic                       w_hit;
    logic [SUM_W:0]             w_addend;
    logic                       w_start_ok;
    logic                       w_commit;

    assign w_sym     = SYM_W'(sym_at(MAX_WORD_W'(r_word), N_SYM, SYM_W, int'(r_idx)));
    assign w_pat_cur = SYM_W'(sym_at(MAX_WORD_W'(r_pat), PAT_LEN, SYM_W, int'(r_pos)));
    assign w_pat0    = r_pat[PAT_LEN*SYM_W-1 -: SYM_W];
    assign w_hit     = (w_sym == w_pat_cur);

    // Running partial plus the current symbol: both the next partial and
    // the value committed when the last pattern symbol matches.
    assign w_addend  = r_partial + (SUM_W+1)'(w_sym);

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_commit   = (r_state == ST_SCAN) && w_hit && (r_pos == POS_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_pat     <= '0;
            r_idx     <= '0;
            r_pos     <= '0;
            r_partial <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_word    <= in;
                        r_pat     <= cypher;
                        r_idx     <= '0;
                        r_pos     <= '0;
                        r_partial <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        if (r_pos == POS_LAST) begin
                            // Non-overlapping: restart from pattern entry 0.
                            r_cnt     <= r_cnt + CNT_W'(1);
                            r_partial <= '0;
                            r_pos     <= '0;
                        end else begin
                            r_partial <= w_addend;
                            r_pos     <= r_pos + POS_W'(1);
                        end
                    end else if (w_sym == w_pat0) begin
                        // The symbol that broke the match opens a new one.
                        r_partial <= (SUM_W+1)'(w_sym);
                        r_pos     <= POS_W'(1);
                    end else begin
                        r_partial <= '0;
                        r_pos     <= '0;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                    // Any partial still open at the last symbol is dropped.
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    cypher_sat_acc #(
        .SUM_W (SUM_W)
    ) u_acc (
        .CLK        (CLK),
        .reset      (reset),
        .i_clr      (w_start_ok),
        .i_commit   (w_commit),
        .i_addend   (w_addend),
        .o_sum      (sum),
        .o_overflow (overflow)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_cypher_scan_accum.sv
module tb_cypher_scan_accum;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] in;
    logic [15:0] cypher;

    // u8: SUM_W=8, u6: SUM_W=6 (saturation); both see the same stimulus.
    logic       busy8, done8, ovf8;
    logic [7:0] sum8;
    logic [2:0] cnt8;
    logic       busy6, done6, ovf6;
    logic [5:0] sum6;
    logic [2:0] cnt6;

    cypher_scan_accum #(.SYM_W(4), .N_SYM(16), .PAT_LEN(4), .SUM_W(8)) u8 (
        .CLK(CLK), .reset(reset), .start(start), .in(in), .cypher(cypher),
        .busy(busy8), .done(done8), .sum(sum8), .match_cnt(cnt8), .overflow(ovf8));

    cypher_scan_accum #(.SYM_W(4), .N_SYM(16), .PAT_LEN(4), .SUM_W(6)) u6 (
        .CLK(CLK), .reset(reset), .start(start), .in(in), .cypher(cypher),
        .busy(busy6), .done(done6), .sum(sum6), .match_cnt(cnt6), .overflow(ovf6));

    always #5 CLK = ~CLK;

    logic sel;
    logic o_busy, o_done, o_ovf;
    int   o_sum, o_cnt;
    always_comb begin
        o_busy = sel ? busy6 : busy8;
        o_done = sel ? done6 : done8;
        o_ovf  = sel ? ovf6  : ovf8;
        o_sum  = sel ? int'(sum6) : int'(sum8);
        o_cnt  = sel ? int'(cnt6) : int'(cnt8);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start sampled at the next edge; inputs scrambled afterwards so a DUT
    // that fails to capture them produces a different result.
    task automatic launch(input logic [15:0] c, input logic [63:0] w);
        cypher = c;
        in     = w;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        in     = ~w;
        cypher = ~c;
    endtask

    // Entered at cycle cyc0 of a run; waits for done and checks the result.
    task automatic finish_run(input string nm, input int cyc0,
                              input int e_cnt, input int e_sum, input int e_ovf);
        int cyc;
        int held;
        cyc = cyc0;
        while (!o_done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({nm, ".latency"}, cyc, 18);
        check({nm, ".cnt"}, o_cnt, e_cnt);
        check({nm, ".sum"}, o_sum, e_sum);
        check({nm, ".ovf"}, int'(o_ovf), e_ovf);
        check({nm, ".busy_at_done"}, int'(o_busy), 0);
        held = o_sum;
        tick();
        check({nm, ".done_one_cycle"}, int'(o_done), 0);
        check({nm, ".held_sum"}, o_sum, e_sum);
        check({nm, ".held_cnt"}, o_cnt, e_cnt);
        if (held != e_sum) check({nm, ".held_vs_done"}, o_sum, held);
    endtask

    typedef struct {
        string       nm;
        logic [15:0] c;
        logic [63:0] w;
        int          cnt;
        int          sum;
    } vec_t;

    vec_t vt[10];

    initial begin
        int cyc;
        int ndone;

        vt[0] = '{"dflt",  16'h1234, 64'h1234_0000_1234_0000, 2, 20};
        vt[1] = '{"brk",   16'h1234, 64'h1212_3400_0000_0000, 1, 10};
        vt[2] = '{"eow",   16'h1234, 64'h0000_0000_0000_0123, 0, 0};
        vt[3] = '{"full4", 16'h1234, 64'h1234_1234_1234_1234, 4, 40};
        vt[4] = '{"allF",  16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4, 240};
        vt[5] = '{"tail",  16'h1111, 64'h1111_1111_1111_1110, 3, 12};
        vt[6] = '{"rst1",  16'h1123, 64'h1112_3000_0000_0000, 0, 0};
        vt[7] = '{"nolap", 16'h1121, 64'h1121_1210_0000_0000, 1, 5};
        vt[8] = '{"zero",  16'h0000, 64'h0000_0000_0000_0000, 4, 0};
        vt[9] = '{"last",  16'hABCD, 64'h0000_0000_0000_ABCD, 1, 46};

        sel    = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        in     = '0;
        cypher = '0;
        tick();
        start  = 1'b1;   // reset wins over start
        tick();
        start  = 1'b0;
        reset  = 1'b0;
        check("rst.busy", int'(o_busy), 0);
        check("rst.done", int'(o_done), 0);
        check("rst.sum", o_sum, 0);
        check("rst.cnt", o_cnt, 0);
        check("rst.ovf", int'(o_ovf), 0);
        tick();
        check("rst.idle_busy", int'(o_busy), 0);

        // Table-driven runs on the SUM_W=8 instance.
        for (int i = 0; i < 10; i++) begin
            launch(vt[i].c, vt[i].w);
            check({vt[i].nm, ".busy_c1"}, int'(o_busy), 1);
            check({vt[i].nm, ".clr_c1"}, o_cnt, 0);
            finish_run(vt[i].nm, 1, vt[i].cnt, vt[i].sum, 0);
        end

        // Saturation plus start-while-busy on the SUM_W=6 instance.
        sel = 1'b1;
        launch(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc = 1;
        while (cyc < 12) begin
            tick();
            cyc++;
            if (cyc == 6) begin
                check("sat.first_sum", o_sum, 60);
                check("sat.first_ovf", int'(o_ovf), 0);
            end
            if (cyc == 10) begin
                check("sat.second_sum", o_sum, 63);
                check("sat.second_ovf", int'(o_ovf), 1);
                check("sat.second_cnt", o_cnt, 2);
            end
        end
        cypher = 16'h1234;
        in     = 64'h1234_0000_1234_0000;
        start  = 1'b1;
        tick();
        cyc++;
        start  = 1'b0;
        finish_run("sat", cyc, 4, 63, 1);

        launch(16'h1234, 64'h1234_0000_1234_0000);
        check("rerun.ovf_cleared", int'(o_ovf), 0);
        check("rerun.sum_cleared", o_sum, 0);
        finish_run("rerun", 1, 2, 20, 0);

        // Reset in the middle of SCAN.
        sel = 1'b0;
        launch(16'h1234, 64'h1234_1234_1234_1234);
        for (int k = 0; k < 9; k++) tick();
        check("midrst.busy_before", int'(o_busy), 1);
        check("midrst.sum_before", o_sum, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst.busy", int'(o_busy), 0);
        check("midrst.done", int'(o_done), 0);
        check("midrst.sum", o_sum, 0);
        check("midrst.cnt", o_cnt, 0);
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (o_done || o_busy) ndone++;
        end
        check("midrst.no_activity", ndone, 0);
        launch(16'h1234, 64'h1234_0000_1234_0000);
        finish_run("postrst", 1, 2, 20, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
